// File: rtl/vram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vram_pkg
// Description : Shared types and constants for the video RAM arbiter and its
//               single-port 300x32 RAM. Holds the arbiter state encoding,
//               the RAM geometry and the byte-address to word-index helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vram_pkg;

  localparam int VRAM_DEPTH  = 300;
  localparam int VRAM_ADDR_W = 9;
  localparam int VRAM_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    VRD  = 3'd1,
    CRD  = 3'd2,
    CWR  = 3'd3,
    ACK  = 3'd4
  } state_e;

  // CPU byte address -> RAM word index (drops the byte lane bits).
  function automatic logic [VRAM_ADDR_W-1:0] word_idx(input logic [31:0] byte_addr);
    return byte_addr[VRAM_ADDR_W+1:2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/vram_sp_ram.sv
`default_nettype none
// ============================================================================
// Module      : vram_sp_ram
// Description : Single-port video RAM, DEPTH x DATA_W, per-byte write enables,
//               registered read (data valid the cycle after en). Read returns
//               the old contents when a write hits the same word.
// Ports       : clk   - clock
//               en    - access strobe
//               we    - byte write enables, bit 3 = [31:24]
//               addr  - word address (accesses >= DEPTH are ignored)
//               wdata - write data
//               rdata - registered read data
// Revision    : 1.0 - initial release
// ============================================================================
module vram_sp_ram
  import vram_pkg::*;
#(
  parameter int DATA_W = VRAM_DATA_W,
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DEPTH  = VRAM_DEPTH
) (
  input  logic                clk,
  input  logic                en,
  input  logic [DATA_W/8-1:0] we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  localparam int NBYTES = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en && (32'(addr) < 32'(DEPTH))) begin
      rdata_q <= mem_q[addr];
      for (int b = 0; b < NBYTES; b++) begin
        if (we[b]) begin
          mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vram_arbiter
// Description : Shares one single-port video RAM between the VGA scan engine
//               (priority) and a CPU req/ack port. A word is fetched each time
//               the scan word address changes and held on vga_data; the CPU
//               gets the RAM in between with byte-enabled writes.
// Ports       : clk, rst_n           - clock, async active-low reset
//               vga_addr / vga_data  - scan word address in, held word out
//               cpu_req/we/be/addr/wdata, cpu_rdata/cpu_ack - CPU handshake
//               ram_en/we/addr/wdata, ram_rdata - RAM port (registered read)
// Revision    : 1.0 - initial release
// ============================================================================
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int DATA_W = VRAM_DATA_W,
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DEPTH  = VRAM_DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [31:0]         vga_addr,
  output logic [DATA_W-1:0]   vga_data,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [3:0]          cpu_be,
  input  logic [31:0]         cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_ack,
  output logic                ram_en,
  output logic [3:0]          ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   tag_q, tag_d;
  logic                tag_valid_q, tag_valid_d;
  logic                vga_cap_q, vga_cap_d;   // ram_rdata holds the VGA word this cycle
  logic                op_rd_q, op_rd_d;       // current CPU op is a read
  logic                op_oor_q, op_oor_d;     // current CPU op is out of range
  logic [DATA_W-1:0]   vga_data_q, vga_data_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                ram_en_q, ram_en_d;
  logic [3:0]          ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;

  logic                vga_in_range;
  logic                vga_pend;
  logic [ADDR_W-1:0]   vga_idx;
  logic [ADDR_W-1:0]   cpu_widx;
  logic                cpu_in_range;
  logic                unused_cpu_addr_bits;

  assign vga_in_range = (vga_addr < 32'(DEPTH));
  assign vga_idx      = vga_addr[ADDR_W-1:0];
  assign vga_pend     = vga_in_range && (!tag_valid_q || (vga_idx != tag_q));

  assign cpu_widx     = word_idx(cpu_addr);
  assign cpu_in_range = (32'(cpu_widx) < 32'(DEPTH));

  // Byte-lane and high address bits carry no meaning for the word RAM.
  assign unused_cpu_addr_bits = ^{cpu_addr[1:0], cpu_addr[31:ADDR_W+2]};

  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    tag_valid_d = tag_valid_q;
    vga_cap_d   = 1'b0;
    op_rd_d     = op_rd_q;
    op_oor_d    = op_oor_q;
    vga_data_d  = vga_cap_q ? ram_rdata : vga_data_q;
    cpu_rdata_d = cpu_rdata_q;
    cpu_ack_d   = 1'b0;
    ram_en_d    = 1'b0;
    ram_we_d    = 4'b0000;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (vga_pend) begin
          state_d    = VRD;
          ram_en_d   = 1'b1;
          ram_addr_d = vga_idx;
        end else if (cpu_req && !cpu_ack_q) begin
          // cpu_ack_q high means this is the ack cycle: the requester is
          // still holding cpu_req for the transaction that just finished.
          op_rd_d    = !cpu_we;
          op_oor_d   = !cpu_in_range;
          ram_en_d   = cpu_in_range;
          ram_addr_d = cpu_widx;
          if (cpu_we) begin
            state_d     = CWR;
            ram_we_d    = cpu_in_range ? cpu_be : 4'b0000;
            ram_wdata_d = cpu_wdata;
            // Writing the displayed word forces a refetch.
            if (cpu_in_range && (cpu_widx == tag_q)) begin
              tag_valid_d = 1'b0;
            end
          end else begin
            state_d = CRD;
          end
        end
      end
      VRD: begin
        // RAM is reading this cycle; the word lands in vga_data one edge later.
        tag_d       = ram_addr_q;
        tag_valid_d = 1'b1;
        vga_cap_d   = 1'b1;
        state_d     = IDLE;
      end
      CRD, CWR: begin
        state_d = ACK;
      end
      ACK: begin
        cpu_ack_d = 1'b1;
        if (op_rd_q) begin
          cpu_rdata_d = op_oor_q ? '0 : ram_rdata;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Blanking overrides any fetch in flight.
    if (!vga_in_range) begin
      tag_valid_d = 1'b0;
      vga_data_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tag_q       <= '0;
      tag_valid_q <= 1'b0;
      vga_cap_q   <= 1'b0;
      op_rd_q     <= 1'b0;
      op_oor_q    <= 1'b0;
      vga_data_q  <= '0;
      cpu_rdata_q <= '0;
      cpu_ack_q   <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 4'b0000;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      tag_valid_q <= tag_valid_d;
      vga_cap_q   <= vga_cap_d;
      op_rd_q     <= op_rd_d;
      op_oor_q    <= op_oor_d;
      vga_data_q  <= vga_data_d;
      cpu_rdata_q <= cpu_rdata_d;
      cpu_ack_q   <= cpu_ack_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign vga_data  = vga_data_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_vram_arbiter
// Description : Directed self-checking bench for vram_arbiter with the
//               vram_sp_ram model attached to its RAM port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;
  import vram_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 9;
  localparam int DEPTH = 300;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   vga_addr;
  logic [DW-1:0] vga_data;
  logic          cpu_req;
  logic          cpu_we;
  logic [3:0]    cpu_be;
  logic [31:0]   cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  vram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .vga_addr  (vga_addr),
    .vga_data  (vga_data),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_be    (cpu_be),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .ram_en    (ram_en),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  vram_sp_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One CPU transaction. Returns cycles from request to the ack cycle and
  // how many of those cycles had ram_en high. Ends one cycle past the ack.
  task automatic cpu_xfer(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output int en_cnt);
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_be    = be;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    lat       = 0;
    en_cnt    = 0;
    while (!cpu_ack && lat < 30) begin
      step(1);
      lat++;
      if (ram_en) en_cnt++;
    end
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    step(1);
  endtask

  initial begin
    int lat;
    int en_cnt;
    int cnt;

    rst_n     = 1'b0;
    vga_addr  = 32'd1000;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_be    = 4'h0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    step(2);

    check_eq("rst_vga_data",  vga_data,            32'h0);
    check_eq("rst_cpu_rdata", cpu_rdata,           32'h0);
    check_eq("rst_cpu_ack",   {31'b0, cpu_ack},    32'h0);
    check_eq("rst_ram_en",    {31'b0, ram_en},     32'h0);
    check_eq("rst_ram_we",    {28'b0, ram_we},     32'h0);
    rst_n = 1'b1;
    step(1);

    // Preload through the CPU port while the scan engine is blanked.
    cpu_xfer(1'b1, 4'hF, 32'h0000_0000, 32'h1111_2222, lat, en_cnt);
    check_eq("wr_lat", lat, 3);
    check_eq("wr_en_cnt", en_cnt, 1);
    cpu_xfer(1'b1, 4'hF, 32'h0000_0010, 32'h4444_4444, lat, en_cnt);
    cpu_xfer(1'b1, 4'hF, 32'h0000_0014, 32'hA1B2_C3D4, lat, en_cnt);
    cpu_xfer(1'b1, 4'hF, 32'h0000_0018, 32'h6666_6666, lat, en_cnt);
    cpu_xfer(1'b1, 4'hF, 32'h0000_001C, 32'h7777_8888, lat, en_cnt);
    check_eq("preload_ram5", u_ram.mem_q[5], 32'hA1B2_C3D4);

    // Reset in the middle of a CPU read: abandoned, no ack.
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h0000_001C;
    step(1);
    check_eq("crd_ram_en", {31'b0, ram_en}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_ram_en", {31'b0, ram_en}, 32'h0);
    cpu_req = 1'b0;
    cnt = 0;
    repeat (3) begin
      step(1);
      if (cpu_ack) cnt++;
    end
    rst_n = 1'b1;
    repeat (4) begin
      step(1);
      if (cpu_ack) cnt++;
    end
    check_eq("rst_mid_no_ack", cnt, 0);
    check_eq("rst_mid_rdata", cpu_rdata, 32'h0);
    check_eq("rst_mid_state", 32'(dut.state_q), 32'(IDLE));

    // VGA fetch latency and hold.
    vga_addr = 32'd4;
    step(6);
    check_eq("vga_w4", vga_data, 32'h4444_4444);
    vga_addr = 32'd5;
    step(2);
    check_eq("vga_lat2_old", vga_data, 32'h4444_4444);
    step(1);
    check_eq("vga_lat3_new", vga_data, 32'hA1B2_C3D4);
    cnt = 0;
    repeat (8) begin
      step(1);
      if (ram_en) cnt++;
    end
    check_eq("vga_no_refetch", cnt, 0);

    // Partial write to the displayed word.
    cpu_xfer(1'b1, 4'b0011, 32'h0000_0014, 32'hFFFF_5566, lat, en_cnt);
    check_eq("bw_lat", lat, 3);
    check_eq("bw_ack_pulse", {31'b0, cpu_ack}, 32'h0);
    check_eq("bw_ram5", u_ram.mem_q[5], 32'hA1B2_5566);
    cnt = 0;
    while (vga_data !== 32'hA1B2_5566 && cnt < 5) begin
      step(1);
      cnt++;
    end
    check_eq("bw_vga_refresh", vga_data, 32'hA1B2_5566);

    // Unblocked read, then a read colliding with a VGA change.
    cpu_xfer(1'b0, 4'h0, 32'h0000_0000, 32'h0, lat, en_cnt);
    check_eq("rd0_lat", lat, 3);
    check_eq("rd0_data", cpu_rdata, 32'h1111_2222);
    vga_addr = 32'd6;
    cpu_xfer(1'b0, 4'h0, 32'h0000_001C, 32'h0, lat, en_cnt);
    check_eq("rd7_blocked_lat", lat, 5);
    check_eq("rd7_data", cpu_rdata, 32'h7777_8888);
    check_eq("vga_w6", vga_data, 32'h6666_6666);

    // Out-of-range CPU accesses.
    cpu_xfer(1'b0, 4'h0, 32'h0000_04B0, 32'h0, lat, en_cnt);
    check_eq("oor_rd_lat", lat, 3);
    check_eq("oor_rd_en", en_cnt, 0);
    check_eq("oor_rd_data", cpu_rdata, 32'h0);
    cpu_xfer(1'b1, 4'hF, 32'h0000_04B0, 32'hDEAD_BEEF, lat, en_cnt);
    check_eq("oor_wr_lat", lat, 3);
    check_eq("oor_wr_en", en_cnt, 0);
    check_eq("oor_wr_ram0", u_ram.mem_q[0], 32'h1111_2222);
    check_eq("oor_wr_ram5", u_ram.mem_q[5], 32'hA1B2_5566);

    // Blanking and return to word 0.
    vga_addr = 32'd1000;
    step(1);
    check_eq("blank_data", vga_data, 32'h0);
    cnt = 0;
    repeat (5) begin
      step(1);
      if (ram_en) cnt++;
    end
    check_eq("blank_no_en", cnt, 0);
    vga_addr = 32'd0;
    step(3);
    check_eq("unblank_w0", vga_data, 32'h1111_2222);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
